// File: rtl/vram_arbiter.sv
// VRAM arbiter: renderer owns the RAM during DRAW, CPU otherwise.
// CPU writes during DRAW are posted into a one-entry buffer.
module vram_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1,
   parameter int STALL_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lcd_ena,
   input  logic [1:0]        phase,
   input  logic [ADDR_W-1:0] ren_addr,
   output logic [DATA_W-1:0] ren_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              wbuf_full,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      ACK     = 2'd2
   } state_e;

   localparam logic [1:0] LAT = 2'(RD_LATENCY);

   state_e              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                wbuf_full_q, wbuf_full_d;
   logic [ADDR_W-1:0]   wbuf_addr_q, wbuf_addr_d;
   logic [DATA_W-1:0]   wbuf_data_q, wbuf_data_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic draw_own;
   logic idle_free;
   logic drain;
   logic wr_direct;
   logic rd_issue;
   logic wr_post;
   logic rd_ones;

   assign draw_own = lcd_ena & (phase == 2'd3);

   // Request decode; a pending buffer always drains before any new CPU access
   always_comb begin
      idle_free = (state_q == IDLE) & ~draw_own;
      drain     = idle_free & wbuf_full_q;
      wr_direct = idle_free & ~wbuf_full_q & cpu_req & cpu_we;
      rd_issue  = idle_free & ~wbuf_full_q & cpu_req & ~cpu_we;
      wr_post   = (state_q == IDLE) & draw_own & ~wbuf_full_q
                  & cpu_req & cpu_we;
      rd_ones   = (state_q == IDLE) & draw_own & cpu_req & ~cpu_we
                  & (STALL_MODE == 0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wbuf_full_q <= 1'b0;
         wbuf_addr_q <= '0;
         wbuf_data_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wbuf_full_q <= wbuf_full_d;
         wbuf_addr_q <= wbuf_addr_d;
         wbuf_data_q <= wbuf_data_d;
         rdata_q     <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wbuf_full_d = wbuf_full_q;
      wbuf_addr_d = wbuf_addr_q;
      wbuf_data_d = wbuf_data_q;
      rdata_d     = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (drain) begin
               wbuf_full_d = 1'b0;
            end else if (wr_direct) begin
               state_d = ACK;
            end else if (wr_post) begin
               state_d     = ACK;
               wbuf_full_d = 1'b1;
               wbuf_addr_d = cpu_addr;
               wbuf_data_d = cpu_wdata;
            end else if (rd_ones) begin
               state_d = ACK;
               rdata_d = '1;
            end else if (rd_issue) begin
               state_d = RD_WAIT;
               cnt_d   = 2'd1;
            end
         end
         // Capture is driven by the counter alone, so DRAW starting
         // mid-flight cannot corrupt a read already issued
         RD_WAIT: begin
            if (cnt_q == LAT) begin
               state_d = ACK;
               rdata_d = ram_rdata;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ram_addr  = draw_own ? ren_addr : cpu_addr;
      ram_we    = 1'b0;
      ram_wdata = cpu_wdata;
      if (drain) begin
         ram_we    = 1'b1;
         ram_addr  = wbuf_addr_q;
         ram_wdata = wbuf_data_q;
      end else if (wr_direct) begin
         ram_we = 1'b1;
      end
   end

   assign cpu_ack   = (state_q == ACK);
   assign cpu_rdata = rdata_q;
   assign wbuf_full = wbuf_full_q;
   assign ren_data  = ram_rdata;

endmodule
